aes_round_sequencer: RTL and testbench

//   FSM for the iterative AES datapath: owns the round counter, round-key index and per-round op selects.

---
 rtl/aes_round_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Round sequencer for the iterative AES datapath: key-expansion kick-off, round stepping and result handoff.
// Optional decrypt support is compiled in with the AES_DECRYPT_EN macro.
module aes_round_sequencer #(
  parameter int NK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       mode,
  input  logic       key_new,
  output logic       kexp_start,
  input  logic       kexp_done,
  output logic       state_load,
  output logic       dp_en,
  output logic       sel_initial,
  output logic       sel_final,
  output logic       dp_inv,
  output logic [3:0] round_idx,
  output logic [3:0] rk_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam int NR = NK + 6;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       key_valid_q, key_valid_d;
  logic       kexp_first_q, kexp_first_d;
  logic       start_ready_q, start_ready_d;
  logic       busy_q, busy_d;
  logic       kexp_start_q, kexp_start_d;
  logic       state_load_q, state_load_d;
  logic       dp_en_q, dp_en_d;
  logic       sel_initial_q, sel_initial_d;
  logic       sel_final_q, sel_final_d;
  logic       dp_inv_q, dp_inv_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic [3:0] rk_addr_q, rk_addr_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic       illegal;

  // Datapath strobes are decoded from the current state and registered, so they
  // trail the state register by one cycle; handshake outputs follow the next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_valid_d   = key_valid_q;
    kexp_first_d  = kexp_first_q;
    dp_inv_d      = dp_inv_q;
    round_idx_d   = round_idx_q;
    rk_addr_d     = rk_addr_q;
    err_d         = err_q;
    kexp_start_d  = 1'b0;
    state_load_d  = 1'b0;
    dp_en_d       = 1'b0;
    sel_initial_d = 1'b0;
    sel_final_d   = 1'b0;
    out_valid_d   = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
`ifdef AES_DECRYPT_EN
          illegal = 1'b0;
`else
          illegal = mode;
`endif
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
`ifdef AES_DECRYPT_EN
            dp_inv_d = mode;
`endif
            if (key_new || !key_valid_q) begin
              state_d      = S_KEXP;
              kexp_first_d = 1'b1;
            end else begin
              state_d = S_INIT;
            end
          end
        end
      end
      S_KEXP: begin
        kexp_first_d = 1'b0;
        kexp_start_d = kexp_first_q;
        // done is not trusted in the cycle the start pulse is still being issued
        if (!kexp_first_q && kexp_done) begin
          key_valid_d = 1'b1;
          state_d     = S_INIT;
        end
      end
      S_INIT: begin
        state_load_d  = 1'b1;
        sel_initial_d = 1'b1;
        round_idx_d   = 4'd0;
        rk_addr_d     = dp_inv_q ? NR_L : 4'd0;
        cnt_d         = 4'd1;
        state_d       = S_ROUND;
      end
      S_ROUND: begin
        dp_en_d     = 1'b1;
        round_idx_d = cnt_q;
        rk_addr_d   = dp_inv_q ? (NR_L - cnt_q) : cnt_q;
        if (cnt_q == NR_L - 4'd1) begin
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FINAL: begin
        dp_en_d     = 1'b1;
        sel_final_d = 1'b1;
        round_idx_d = NR_L;
        rk_addr_d   = dp_inv_q ? 4'd0 : NR_L;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        round_idx_d = NR_L;
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      key_valid_q   <= 1'b0;
      kexp_first_q  <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      kexp_start_q  <= 1'b0;
      state_load_q  <= 1'b0;
      dp_en_q       <= 1'b0;
      sel_initial_q <= 1'b0;
      sel_final_q   <= 1'b0;
      dp_inv_q      <= 1'b0;
      round_idx_q   <= 4'd0;
      rk_addr_q     <= 4'd0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_valid_q   <= key_valid_d;
      kexp_first_q  <= kexp_first_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      kexp_start_q  <= kexp_start_d;
      state_load_q  <= state_load_d;
      dp_en_q       <= dp_en_d;
      sel_initial_q <= sel_initial_d;
      sel_final_q   <= sel_final_d;
      dp_inv_q      <= dp_inv_d;
      round_idx_q   <= round_idx_d;
      rk_addr_q     <= rk_addr_d;
      out_valid_q   <= out_valid_d;
      err_q         <= err_d;
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign kexp_start  = kexp_start_q;
  assign state_load  = state_load_q;
  assign dp_en       = dp_en_q;
  assign sel_initial = sel_initial_q;
  assign sel_final   = sel_final_q;
  assign dp_inv      = dp_inv_q;
  assign round_idx   = round_idx_q;
  assign rk_addr     = rk_addr_q;
  assign out_valid   = out_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: per-cycle expected trace built from the round schedule, plus literal pins.
// Handshake: a request moves on an edge where start_valid and start_ready are both high; a result on out_valid and out_ready.
module tb_aes_round_sequencer;

`ifdef AES_DECRYPT_EN
  localparam int NK      = 8;
  localparam bit DEC_EN  = 1'b1;
  localparam int LAT_LIT = 16;
  localparam int ENC_LEN = 15;
`else
  localparam int NK      = 4;
  localparam bit DEC_EN  = 1'b0;
  localparam int LAT_LIT = 12;
  localparam int ENC_LEN = 11;
`endif
  localparam int NR = NK + 6;

  localparam logic [17:0] RESET_V = 18'h20000;
  localparam logic [17:0] FULL_M  = 18'h3FFFF;
  localparam logic [17:0] CTRL_M  = 18'h3FF00;
  localparam logic [17:0] HOLD_M  = 18'h3FFF0;

  logic       clk, rst_n;
  logic       start_valid, start_ready, mode, key_new;
  logic       kexp_start, kexp_done;
  logic       state_load, dp_en, sel_initial, sel_final, dp_inv;
  logic [3:0] round_idx, rk_addr;
  logic       out_valid, out_ready, busy, err;

  aes_round_sequencer #(.NK(NK)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .key_new(key_new),
    .kexp_start(kexp_start), .kexp_done(kexp_done),
    .state_load(state_load), .dp_en(dp_en),
    .sel_initial(sel_initial), .sel_final(sel_final), .dp_inv(dp_inv),
    .round_idx(round_idx), .rk_addr(rk_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] act_v;
  assign act_v = {start_ready, busy, kexp_start, state_load, dp_en, sel_initial,
                  sel_final, dp_inv, out_valid, err, round_idx, rk_addr};

  typedef struct {
    int          cyc;
    logic [17:0] v;
    logic [17:0] m;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_e;
  int         checks = 0;
  int         errors = 0;
  int         push_limit = 32'h7fffffff;
  bit         rec_en = 1'b0;
  logic [3:0] rk_rec[$];
  int         ov_cyc = -1;
  int         last_a = 0;

  bit m_key_valid = 1'b0;
  bit m_err = 1'b0;
  bit m_inv = 1'b0;

  function automatic logic [17:0] vec(input bit sr, input bit bsy, input bit ks, input bit sl,
                                      input bit de, input bit si, input bit sf, input bit inv,
                                      input bit ov, input bit er, input int ri, input int rk);
    logic [3:0] r4;
    logic [3:0] k4;
    r4 = ri[3:0];
    k4 = rk[3:0];
    return {sr, bsy, ks, sl, de, si, sf, inv, ov, er, r4, k4};
  endfunction

  task automatic push(input int c, input logic [17:0] v, input logic [17:0] m);
    exp_t e2;
    if (c < push_limit) begin
      e2.cyc = c;
      e2.v   = v;
      e2.m   = m;
      exp_q.push_back(e2);
    end
  endtask

  // scoreboard: every queued expectation is checked at the falling edge of its cycle
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        cur_e = exp_q.pop_front();
        checks++;
        if (cur_e.cyc != cyc || ((act_v ^ cur_e.v) & cur_e.m) != 18'h0) begin
          errors++;
          $display("FAIL trace cyc=%0d want_cyc=%0d got=%05h want=%05h mask=%05h",
                   cyc, cur_e.cyc, act_v, cur_e.v, cur_e.m);
        end
      end
      if (rec_en && (dp_en || state_load)) rk_rec.push_back(rk_addr);
      if (rec_en && out_valid && ov_cyc < 0) ov_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(cyc, vec(1, 0, 0, 0, 0, 0, 0, m_inv, 0, m_err, 0, 0), CTRL_M);
      step();
    end
  endtask

  // driver: one request; model trace is laid down first, then inputs are played out
  task automatic run_op(input bit m, input bit kn, input int kwait, input int hwait,
                        input bit early, input bit stray, input int abort_round);
    int a, b, v, r, end_c;
    bit kx, inv;
    a      = cyc + 1;
    last_a = a;
    start_valid = 1'b1;
    mode        = m;
    key_new     = kn;
    out_ready   = early;
    if (!DEC_EN && m) begin
      m_err = 1'b1;
      push(a, vec(1, 0, 0, 0, 0, 0, 0, m_inv, 0, 1, 0, 0), CTRL_M);
      step();
      start_valid = 1'b0;
      mode        = 1'b0;
      key_new     = 1'b0;
      out_ready   = 1'b0;
      return;
    end
    m_err = 1'b0;
    m_inv = DEC_EN ? m : 1'b0;
    inv   = m_inv;
    kx    = kn || !m_key_valid;
    b     = kx ? a + 2 + kwait : a;
    v     = b + NR + 2;
    end_c = v + hwait + 1;
    r     = (abort_round >= 0) ? b + 1 + abort_round : end_c + 100;
    push_limit = r;
    push(a, vec(0, 1, 0, 0, 0, 0, 0, inv, 0, 0, 0, 0), CTRL_M);
    if (kx) begin
      for (int c = a + 1; c <= b; c++)
        push(c, vec(0, 1, (c == a + 1), 0, 0, 0, 0, inv, 0, 0, 0, 0), CTRL_M);
      m_key_valid = 1'b1;
    end
    for (int k = 0; k <= NR; k++) begin
      if (k == 0)
        push(b + 1, vec(0, 1, 0, 1, 0, 1, 0, inv, 0, 0, 0, inv ? NR : 0), FULL_M);
      else if (k < NR)
        push(b + 1 + k, vec(0, 1, 0, 0, 1, 0, 0, inv, 0, 0, k, inv ? NR - k : k), FULL_M);
      else
        push(b + 1 + k, vec(0, 1, 0, 0, 1, 0, 1, inv, 0, 0, NR, inv ? 0 : NR), FULL_M);
    end
    for (int c = v; c < end_c; c++)
      push(c, vec(0, 1, 0, 0, 0, 0, 0, inv, 1, 0, NR, 0), HOLD_M);
    push(end_c, vec(1, 0, 0, 0, 0, 0, 0, inv, 0, 0, 0, 0), CTRL_M);
    push_limit = 32'h7fffffff;
    if (abort_round >= 0) push(r, RESET_V, FULL_M);
    step();
    for (int c = a; c <= end_c; c++) begin
      if (c == r) begin
        #1;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        kexp_done   = 1'b0;
        out_ready   = 1'b0;
        m_key_valid = 1'b0;
        m_err       = 1'b0;
        m_inv       = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        break;
      end
      start_valid = (c < end_c) ? ($urandom_range(0, 1) != 0) : 1'b0;
      mode        = ($urandom_range(0, 1) != 0);
      key_new     = ($urandom_range(0, 1) != 0);
      kexp_done   = (kx && c == b - 1) || (stray && c == b + 3);
      out_ready   = early || (c >= v + hwait);
      step();
    end
    start_valid = 1'b0;
    mode        = 1'b0;
    key_new     = 1'b0;
    kexp_done   = 1'b0;
    out_ready   = 1'b0;
  endtask

  task automatic pin_rk(input string name, input int exp_a[]);
    bit bad;
    checks++;
    bad = (rk_rec.size() != exp_a.size());
    for (int i = 0; i < exp_a.size() && !bad; i++)
      if (int'(rk_rec[i]) != exp_a[i]) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL %s got_len=%0d want_len=%0d got=%p want=%p", name, rk_rec.size(),
               exp_a.size(), rk_rec, exp_a);
    end
  endtask

  initial begin
    int enc_lit[];
    int dec_lit[];
`ifdef AES_DECRYPT_EN
    enc_lit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    dec_lit = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
`else
    enc_lit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    dec_lit = '{0};
`endif
    rst_n = 1'b0;
    start_valid = 1'b0;
    mode = 1'b0;
    key_new = 1'b0;
    kexp_done = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, RESET_V, FULL_M);
    rst_n = 1'b1;
    step();
    idle(2);

    // first block: key expansion, then encrypt
    rk_rec.delete();
    rec_en = 1'b1;
    run_op(0, 1, 4, 0, 0, 0, -1);
    rec_en = 1'b0;
    if (ENC_LEN == enc_lit.size()) pin_rk("enc_rk_order", enc_lit);
    idle(2);

    // cached key, result held for 7 cycles
    ov_cyc = -1;
    rec_en = 1'b1;
    run_op(0, 0, 0, 7, 0, 0, -1);
    rec_en = 1'b0;
    checks++;
    if (ov_cyc - last_a != LAT_LIT) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d", ov_cyc - last_a, LAT_LIT);
    end
    idle(1);

    // early out_ready and a stray kexp_done during rounds
    run_op(0, 0, 0, 0, 1, 1, -1);
    idle(1);

    // mode=1: decrypt when built with decrypt, otherwise rejected with err
    rk_rec.delete();
    rec_en = 1'b1;
    run_op(1, 0, 0, 2, 0, 0, -1);
    rec_en = 1'b0;
`ifdef AES_DECRYPT_EN
    pin_rk("dec_rk_order", dec_lit);
`endif
    idle(2);
    run_op(0, 0, 0, 0, 0, 0, -1);
    idle(1);

    // reset during round 5, then a cached-key request must re-expand
    run_op(0, 0, 0, 0, 0, 0, 5);
    idle(2);
    run_op(0, 0, 2, 1, 0, 0, -1);
    idle(2);
`ifdef AES_DECRYPT_EN
    run_op(1, 1, 3, 0, 0, 0, -1);
    idle(2);
`endif
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
